ttt_prog_loader: RTL and testbench
==================================

TTT_PROG_LOADER -- requirements
Module: ttt_prog_loader

Interface
REQ-001 SHALL have parameter NUM_PROCESSORS, default 10, number of addressable processors.
REQ-002 SHALL have parameter NUM_CONNECTIONS, default 50, number of addressable connections.
REQ-003 SHALL have parameter PROG_WIDTH, default 8, programming data width; values other than 8 are unsupported.
REQ-004 SHALL have port clock_fast  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  8  programming byte stream.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port instruction  output  5  instruction to the token-network programming port; 0 = NOP.
REQ-010 SHALL have port prog_data  output  PROG_WIDTH  programming operand.
REQ-011 SHALL have port processor_id  output  $clog2(NUM_PROCESSORS)  target processor.
REQ-012 SHALL have port connection_id  output  $clog2(NUM_CONNECTIONS)  target connection.
REQ-013 SHALL have port done  output  1  end-of-program seen.
REQ-014 SHALL have port err  output  1  sticky frame error.
REQ-015 SHALL have port frame_count  output  8  instructions issued, saturating at 255.

Function
REQ-016 Byte transfer SHALL occur only on cycles with in_valid && in_ready; in_ready SHALL not depend combinationally on in_valid.
REQ-017 Frame SHALL be HDR, PID, CID, DATA bytes, plus CSUM when checksum is enabled; HDR[4:0] is the instruction, HDR[6:5] are ignored, and HDR[7]=1 is the END marker.
REQ-018 FSM states SHALL be S_HDR, S_PID, S_CID, S_DATA, [S_CSUM], S_ISSUE, S_GAP, S_DONE; each byte state advances by one state per accepted byte.
REQ-019 In S_HDR, an END header SHALL go to S_DONE, and an instruction-0 header SHALL be discarded with no state change.
REQ-020 in_ready SHALL be 1 in S_HDR through S_DATA/S_CSUM and 0 in S_ISSUE, S_GAP and S_DONE.
REQ-021 In S_ISSUE, instruction SHALL equal the latched opcode for exactly one cycle; in all other states, instruction SHALL be 0.
REQ-022 processor_id, connection_id and prog_data SHALL be stable from S_ISSUE through the end of S_GAP.
REQ-023 Latency from the DATA (or CSUM) byte handshake to instruction≠0 SHALL be exactly 1 cycle.
REQ-024 S_GAP SHALL last exactly 1 cycle and then return to S_HDR, giving at most 1 issue per 6 cycles.
REQ-025 A PID byte ≥ NUM_PROCESSORS, or a CID byte ≥ NUM_CONNECTIONS, SHALL set err, complete byte collection, skip S_ISSUE and return to S_HDR.
REQ-026 frame_count SHALL increment on each S_ISSUE cycle and hold at 255.
REQ-027 In S_DONE, done SHALL be 1 and the state SHALL hold until reset; further bytes are back-pressured.

Reset
REQ-028 On reset, state SHALL be S_HDR, instruction, prog_data, processor_id and connection_id 0, in_ready 1 on the following cycle, and done, err and frame_count 0.
REQ-029 Reset mid-frame SHALL discard the partial frame, and no instruction SHALL be issued for it.

Configuration
REQ-030 Macro TTT_PROG_CHECKSUM_EN defined: S_CSUM SHALL be present, and a frame is valid only if the XOR of HDR, PID, CID, DATA and CSUM is 0x00.
REQ-031 On checksum mismatch, the loader SHALL set err and skip S_ISSUE, in addition to the range checks of REQ-025.
REQ-032 Macro undefined: S_CSUM SHALL be absent, frames are 4 bytes, and no checksum logic SHALL exist.

Structure
REQ-033 Shared package ttt_pkg SHALL hold the FSM state enum, the instruction NOP constant (0), the END header bit index (7) and the frame byte-count constants.
REQ-034 Frame-field latching plus range and checksum checks SHALL be one sub-module, ttt_prog_frame_check; the FSM and counter stay in ttt_prog_loader.

Verification
REQ-035 Bytes 0x03,0x02,0x05,0x7A with in_valid held -> instruction=3, processor_id=2, connection_id=5, prog_data=0x7A for one cycle, 1 cycle after the 4th handshake; frame_count=1.
REQ-036 Same frame with in_valid toggling every other cycle -> identical outputs; no byte lost or duplicated.
REQ-037 PID=0x0A (equal to NUM_PROCESSORS) -> err=1, instruction stays 0, frame_count=0, and the next valid frame issues normally.
REQ-038 Header 0x80 -> done=1 next cycle, in_ready=0 thereafter.
REQ-039 Reset asserted after 2 bytes, then a full valid frame -> exactly one issue, matching the second frame.
REQ-040 With TTT_PROG_CHECKSUM_EN: 0x01,0x01,0x01,0x01,0x00 -> issue; CSUM=0x01 -> err=1, no issue.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared FSM states and frame constants for the TTT programming loader.
// Define TTT_PROG_CHECKSUM_EN to add a trailing XOR checksum byte to every frame.
package ttt_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_PID,
    S_CID,
    S_DATA,
`ifdef TTT_PROG_CHECKSUM_EN
    S_CSUM,
`endif
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [4:0] INSTR_NOP = 5'd0;
  localparam int         END_BIT   = 7;

`ifdef TTT_PROG_CHECKSUM_EN
  localparam int FRAME_BYTES = 5;
`else
  localparam int FRAME_BYTES = 4;
`endif

endpackage

// File: rtl/ttt_prog_frame_check.sv
// Latches frame fields byte by byte and flags out-of-range ids (and bad checksum
// when TTT_PROG_CHECKSUM_EN is defined); o_bad is valid on the frame's last byte.
module ttt_prog_frame_check
  import ttt_pkg::*;
#(
  parameter int NUM_PROCESSORS  = 10,
  parameter int NUM_CONNECTIONS = 50,
  parameter int PROG_WIDTH      = 8,
  localparam int PID_W = $clog2(NUM_PROCESSORS),
  localparam int CID_W = $clog2(NUM_CONNECTIONS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_byte,
  input  logic                  i_load,
  output logic [4:0]            o_opcode,
  output logic [PID_W-1:0]      o_pid,
  output logic [CID_W-1:0]      o_cid,
  output logic [PROG_WIDTH-1:0] o_data,
  output logic                  o_bad
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  logic [2:0]            r_idx;
  logic [4:0]            r_opcode;
  logic [PID_W-1:0]      r_pid;
  logic [CID_W-1:0]      r_cid;
  logic [PROG_WIDTH-1:0] r_data;
  logic                  r_range_bad;
  logic                  w_pid_oor;
  logic                  w_cid_oor;

  assign w_pid_oor = int'(i_byte) >= NUM_PROCESSORS;
  assign w_cid_oor = int'(i_byte) >= NUM_CONNECTIONS;

`ifdef TTT_PROG_CHECKSUM_EN
  logic [7:0] r_xor;
  // The incoming CSUM byte closes the XOR, so a good frame folds to zero.
  assign o_bad = r_range_bad | ((r_xor ^ i_byte) != 8'h00);
`else
  assign o_bad = r_range_bad;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx       <= 3'd0;
      r_opcode    <= INSTR_NOP;
      r_pid       <= '0;
      r_cid       <= '0;
      r_data      <= '0;
      r_range_bad <= 1'b0;
`ifdef TTT_PROG_CHECKSUM_EN
      r_xor       <= 8'h00;
`endif
    end else if (i_load) begin
      r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
      case (r_idx)
        3'd0: begin
          r_opcode    <= i_byte[4:0];
          r_range_bad <= 1'b0;
        end
        3'd1: begin
          r_pid       <= i_byte[PID_W-1:0];
          r_range_bad <= w_pid_oor;
        end
        3'd2: begin
          r_cid       <= i_byte[CID_W-1:0];
          r_range_bad <= r_range_bad | w_cid_oor;
        end
        3'd3:    r_data <= PROG_WIDTH'(i_byte);
        default: ;
      endcase
`ifdef TTT_PROG_CHECKSUM_EN
      r_xor <= (r_idx == 3'd0) ? i_byte : (r_xor ^ i_byte);
`endif
    end
  end

  assign o_opcode = r_opcode;
  assign o_pid    = r_pid;
  assign o_cid    = r_cid;
  assign o_data   = r_data;

endmodule

// File: rtl/ttt_prog_loader.sv
// Byte-stream loader issuing one token-network programming instruction per frame,
// 1 cycle after the last byte; in_ready drops during issue/gap and after END.
module ttt_prog_loader
  import ttt_pkg::*;
#(
  parameter int NUM_PROCESSORS  = 10,
  parameter int NUM_CONNECTIONS = 50,
  parameter int PROG_WIDTH      = 8
) (
  input  logic                               clock_fast,
  input  logic                               reset,
  input  logic [7:0]                         in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [4:0]                         instruction,
  output logic [PROG_WIDTH-1:0]              prog_data,
  output logic [$clog2(NUM_PROCESSORS)-1:0]  processor_id,
  output logic [$clog2(NUM_CONNECTIONS)-1:0] connection_id,
  output logic                               done,
  output logic                               err,
  output logic [7:0]                         frame_count
);

  state_t     r_state;
  logic       r_in_ready;
  logic [4:0] r_instruction;
  logic       r_done;
  logic       r_err;
  logic [7:0] r_frame_count;

  logic       w_xfer;
  logic       w_hdr_skip;
  logic       w_load;
  logic [4:0] w_opcode;
  logic       w_frame_bad;

  assign w_xfer     = in_valid && r_in_ready;
  assign w_hdr_skip = in_data[END_BIT] || (in_data[4:0] == INSTR_NOP);
  // END and NOP headers never start a frame, so they must not reach the field latches.
  assign w_load     = w_xfer && !((r_state == S_HDR) && w_hdr_skip);

  ttt_prog_frame_check #(
    .NUM_PROCESSORS (NUM_PROCESSORS),
    .NUM_CONNECTIONS(NUM_CONNECTIONS),
    .PROG_WIDTH     (PROG_WIDTH)
  ) u_frame_check (
    .i_clk   (clock_fast),
    .i_reset (reset),
    .i_byte  (in_data),
    .i_load  (w_load),
    .o_opcode(w_opcode),
    .o_pid   (processor_id),
    .o_cid   (connection_id),
    .o_data  (prog_data),
    .o_bad   (w_frame_bad)
  );

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      r_state       <= S_HDR;
      r_in_ready    <= 1'b1;
      r_instruction <= INSTR_NOP;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_instruction <= INSTR_NOP;
      case (r_state)
        S_HDR: if (w_xfer) begin
          if (in_data[END_BIT]) begin
            r_state    <= S_DONE;
            r_in_ready <= 1'b0;
            r_done     <= 1'b1;
          end else if (in_data[4:0] != INSTR_NOP) begin
            r_state <= S_PID;
          end
        end
        S_PID: if (w_xfer) r_state <= S_CID;
        S_CID: if (w_xfer) r_state <= S_DATA;
`ifdef TTT_PROG_CHECKSUM_EN
        S_DATA: if (w_xfer) r_state <= S_CSUM;
        S_CSUM: if (w_xfer) begin
`else
        S_DATA: if (w_xfer) begin
`endif
          if (w_frame_bad) begin
            r_err   <= 1'b1;
            r_state <= S_HDR;
          end else begin
            r_state       <= S_ISSUE;
            r_in_ready    <= 1'b0;
            r_instruction <= w_opcode;
          end
        end
        S_ISSUE: begin
          r_state <= S_GAP;
          if (r_frame_count != 8'hFF) r_frame_count <= r_frame_count + 8'd1;
        end
        S_GAP: begin
          r_state    <= S_HDR;
          r_in_ready <= 1'b1;
        end
        S_DONE: r_state <= S_DONE;
        default: begin
          r_state    <= S_HDR;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign instruction = r_instruction;
  assign done        = r_done;
  assign err         = r_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_ttt_prog_loader.sv
// Self-checking bench for ttt_prog_loader: directed frame table, reset/END/checksum
// sequences and a randomized frame stream checked against a frame-level model.
module tb_ttt_prog_loader;

  localparam int NP = 10;
  localparam int NC = 50;
`ifdef TTT_PROG_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] instruction;
  logic [7:0] prog_data;
  logic [3:0] processor_id;
  logic [5:0] connection_id;
  logic       done;
  logic       err;
  logic [7:0] frame_count;

  ttt_prog_loader #(.NUM_PROCESSORS(NP), .NUM_CONNECTIONS(NC), .PROG_WIDTH(8)) dut (
    .clock_fast   (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instruction  (instruction),
    .prog_data    (prog_data),
    .processor_id (processor_id),
    .connection_id(connection_id),
    .done         (done),
    .err          (err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  bit tog = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [22:0] fields;  // {instr, pid, cid, data}
    int          cyc;
  } iss_t;

  iss_t        obs_q[$];
  logic [17:0] gap_q[$];   // {pid, cid, data} one cycle after issue
  logic [22:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue monitor: records every non-NOP instruction and the operands one cycle later.
  bit prev_iss = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_iss = 1'b0;
    end else begin
      if (prev_iss) gap_q.push_back({processor_id, connection_id, prog_data});
      if (instruction != 5'd0) begin
        chk("issue_one_cycle", 32'(prev_iss), 32'd0);
        chk("issue_in_ready_low", 32'(in_ready), 32'd0);
        obs_q.push_back('{{instruction, processor_id, connection_id, prog_data}, cyc});
      end
      prev_iss = (instruction != 5'd0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // mode 0: valid held, 1: valid every other cycle, 2: random valid
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit v;
    for (int tries = 0; tries < 100; tries++) begin
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      in_valid = v;
      in_data  = v ? b : 8'($urandom);
      if (v && in_ready) begin
        last_hs_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int mode);
    send_byte(b0, mode);
    send_byte(b1, mode);
    send_byte(b2, mode);
    send_byte(b3, mode);
    if (CSUM) send_byte(b0 ^ b1 ^ b2 ^ b3, mode);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    int         mode;
    bit         pre0;
    bit         exp_issue;
    logic [4:0] exp_instr;
    bit         exp_err;
    int         exp_cnt;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [7:0] hdr, pid, cid, dat, x;
    int         m_cnt;
    bit         m_err;
    bit         ok;
    int         nmin;

    vt[0] = '{8'h03, 8'h02, 8'h05, 8'h7A, 0, 1'b0, 1'b1, 5'd3,  1'b0, 1};
    vt[1] = '{8'h03, 8'h02, 8'h05, 8'h7A, 1, 1'b0, 1'b1, 5'd3,  1'b0, 2};
    vt[2] = '{8'h01, 8'h0A, 8'h00, 8'h11, 0, 1'b0, 1'b0, 5'd0,  1'b1, 2};
    vt[3] = '{8'h1F, 8'h09, 8'h31, 8'hFF, 1, 1'b0, 1'b1, 5'd31, 1'b1, 3};
    vt[4] = '{8'h65, 8'h00, 8'h00, 8'h00, 2, 1'b1, 1'b1, 5'd5,  1'b1, 4};
    vt[5] = '{8'h02, 8'h00, 8'h32, 8'h00, 0, 1'b0, 1'b0, 5'd0,  1'b1, 4};

    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_instruction", 32'(instruction), 32'd0);
    chk("rst_prog_data", 32'(prog_data), 32'd0);
    chk("rst_processor_id", 32'(processor_id), 32'd0);
    chk("rst_connection_id", 32'(connection_id), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);

    for (int i = 0; i < 6; i++) begin
      obs_q.delete();
      gap_q.delete();
      if (vt[i].pre0) send_byte(8'h60, 0);
      send_frame(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].b3, vt[i].mode);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_issue_count", i), 32'(obs_q.size()), 32'(vt[i].exp_issue));
      if (vt[i].exp_issue && obs_q.size() == 1 && gap_q.size() == 1) begin
        chk($sformatf("v%0d_issue_fields", i), 32'(obs_q[0].fields),
            32'({vt[i].exp_instr, vt[i].b1[3:0], vt[i].b2[5:0], vt[i].b3}));
        chk($sformatf("v%0d_latency", i), 32'(obs_q[0].cyc - last_hs_cyc), 32'd1);
        chk($sformatf("v%0d_gap_stable", i), 32'(gap_q[0]),
            32'({vt[i].b1[3:0], vt[i].b2[5:0], vt[i].b3}));
      end
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].exp_err));
      chk($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(vt[i].exp_cnt));
    end

    // Reset after two bytes of a frame: the partial frame must vanish.
    do_reset();
    obs_q.delete();
    gap_q.delete();
    send_byte(8'h04, 0);
    send_byte(8'h03, 0);
    do_reset();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_err_count", 32'({err, frame_count}), 32'd0);
    send_frame(8'h06, 8'h01, 8'h02, 8'h33, 0);
    repeat (4) @(negedge clk);
    chk("midrst_issue_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1)
      chk("midrst_issue_fields", 32'(obs_q[0].fields), 32'({5'd6, 4'd1, 6'd2, 8'h33}));
    chk("midrst_frame_count", 32'(frame_count), 32'd1);

`ifdef TTT_PROG_CHECKSUM_EN
    do_reset();
    obs_q.delete();
    send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    repeat (4) @(negedge clk);
    chk("csum_good_issue", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1)
      chk("csum_good_fields", 32'(obs_q[0].fields), 32'({5'd1, 4'd1, 6'd1, 8'h01}));
    chk("csum_good_err", 32'(err), 32'd0);
    obs_q.delete();
    send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    repeat (4) @(negedge clk);
    chk("csum_bad_issue", 32'(obs_q.size()), 32'd0);
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_count", 32'(frame_count), 32'd1);
`endif

    // Random frame stream against a frame-level model; long enough to saturate the count.
    do_reset();
    obs_q.delete();
    exp_q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_byte({1'b0, 2'($urandom), 5'd0}, 2);
      end else begin
        hdr = {1'b0, 2'($urandom), 5'($urandom_range(1, 31))};
        pid = 8'($urandom_range(0, 11));
        cid = 8'($urandom_range(0, 52));
        dat = 8'($urandom);
        x   = hdr ^ pid ^ cid ^ dat;
        if ($urandom_range(0, 9) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
        send_byte(hdr, 2);
        send_byte(pid, 2);
        send_byte(cid, 2);
        send_byte(dat, 2);
        if (CSUM) send_byte(x, 2);
        ok = (int'(pid) < NP) && (int'(cid) < NC) && (!CSUM || ((hdr ^ pid ^ cid ^ dat ^ x) == 8'h00));
        if (ok) begin
          exp_q.push_back({hdr[4:0], pid[3:0], cid[5:0], dat});
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    repeat (4) @(negedge clk);
    chk("rand_issue_count", 32'(obs_q.size()), 32'(exp_q.size()));
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < nmin; k++)
      chk($sformatf("rand_issue_%0d", k), 32'(obs_q[k].fields), 32'(exp_q[k]));
    chk("rand_frame_count", 32'(frame_count), 32'(m_cnt));
    chk("rand_err", 32'(err), 32'(m_err));

    // END header: done next cycle, input back-pressured for good.
    chk("pre_end_done", 32'(done), 32'd0);
    nmin = obs_q.size();
    send_byte(8'h80, 0);
    @(negedge clk);
    chk("end_done", 32'(done), 32'd1);
    chk("end_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h03;
      @(negedge clk);
      chk($sformatf("end_hold_%0d", k), 32'({done, in_ready}), 32'b10);
    end
    in_valid = 1'b0;
    chk("end_no_issue", 32'(obs_q.size()), 32'(nmin));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
